// File: rtl/vote_pkg.sv
// Shared definitions for the voting session block: FSM state encoding
// and a population-count helper used to tally accepted votes.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        TALLY = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int MAX_VOTERS = 32;

    // Counts the ones in a vector wide enough for the largest voter pool
    function automatic logic [5:0] popcount(input logic [MAX_VOTERS-1:0] vec);
        logic [5:0] total;
        total = '0;
        for (int i = 0; i < MAX_VOTERS; i++) begin
            total = total + {5'd0, vec[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational tally of the votes accepted on one edge, split into
// yes and no, so the top can add both to its running counts at once.
module vote_popcount #(
    parameter int N = 5,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  accepted,
    input  logic [N-1:0]  vote_yes,
    output logic [CW-1:0] yes_add,
    output logic [CW-1:0] no_add
);
    import vote_pkg::*;

    logic [MAX_VOTERS-1:0] yes_vec;
    logic [MAX_VOTERS-1:0] no_vec;

    // Widen the accepted yes/no masks to the helper's fixed width
    always_comb begin
        yes_vec = '0;
        no_vec  = '0;
        yes_vec[N-1:0] = accepted & vote_yes;
        no_vec[N-1:0]  = accepted & ~vote_yes;
    end

    assign yes_add = CW'(popcount(yes_vec));
    assign no_add  = CW'(popcount(no_vec));

endmodule

// File: rtl/vote_session.sv
// Timed voting session for N voters. Opens on start, latches each voter's
// first vote, closes on all-voted / timeout / early decision, then holds
// the tallied result until the next start. Abort cancels a live session.
module vote_session #(
    parameter int N       = 5,
    parameter int THRESH  = N / 2 + 1,
    parameter int TIMEOUT = 1000,
    parameter int EARLY   = 0,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  vote_en,
    input  logic [N-1:0]  vote_yes,
    output logic          busy,
    output logic [N-1:0]  voted,
    output logic [CW-1:0] yes_cnt,
    output logic [CW-1:0] no_cnt,
    output logic          result,
    output logic          result_valid,
    output logic          done
);
    import vote_pkg::*;

    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int NO_LIMIT = N - THRESH;

    state_t        state;
    state_t        next_state;
    logic          clear;
    logic          accept;
    logic          finish;
    logic          early_hit;
    logic          close_cond;
    logic [N-1:0]  accepted;
    logic [CW-1:0] yes_add;
    logic [CW-1:0] no_add;
    logic [TW-1:0] timer;

    // Closing decisions use the registered counts, so they act one edge later
    assign early_hit  = (EARLY != 0) &&
                        ((int'(yes_cnt) >= THRESH) || (int'(no_cnt) > NO_LIMIT));
    assign close_cond = (&voted) || (timer == TW'(TIMEOUT - 1)) || early_hit;
    assign busy       = (state == OPEN) || (state == TALLY);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-edge control strobes; abort outranks everything while live
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = OPEN;
                    clear      = 1'b1;
                end
            end
            OPEN: begin
                if (abort) begin
                    next_state = IDLE;
                    clear      = 1'b1;
                end else begin
                    accept = 1'b1;
                    if (close_cond) begin
                        next_state = TALLY;
                    end
                end
            end
            TALLY: begin
                if (abort) begin
                    next_state = IDLE;
                    clear      = 1'b1;
                end else begin
                    next_state = HOLD;
                    finish     = 1'b1;
                end
            end
            HOLD: begin
                if (start) begin
                    next_state = OPEN;
                    clear      = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                clear      = 1'b1;
            end
        endcase
        accepted = accept ? (vote_en & ~voted) : '0;
    end

    vote_popcount #(.N(N)) u_popcount (
        .accepted (accepted),
        .vote_yes (vote_yes),
        .yes_add  (yes_add),
        .no_add   (no_add)
    );

    // Session datapath: voted mask, counts, timer and the held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted        <= '0;
            yes_cnt      <= '0;
            no_cnt       <= '0;
            timer        <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else if (clear) begin
            voted        <= '0;
            yes_cnt      <= '0;
            no_cnt       <= '0;
            timer        <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                voted   <= voted | accepted;
                yes_cnt <= yes_cnt + yes_add;
                no_cnt  <= no_cnt + no_add;
                timer   <= timer + TW'(1);
            end
            if (finish) begin
                result       <= (int'(yes_cnt) >= THRESH);
                result_valid <= 1'b1;
                done         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vote_session.sv
// Bench for vote_session: two instances (plain with short timeout, and
// early-decision) share one stimulus stream and are checked every cycle
// against a vote-list model, plus directed constant checks per scenario.
module tb_vote_session;

    localparam int N  = 5;
    localparam int TH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] vote_en = '0;
    logic [4:0] vote_yes = '0;

    logic       busy [2];
    logic [4:0] voted [2];
    logic [2:0] yes_cnt [2];
    logic [2:0] no_cnt [2];
    logic       result [2];
    logic       result_valid [2];
    logic       done [2];

    int errors = 0;
    int checks = 0;

    int timeout_m [2];
    int early_m [2];
    int m_phase [2];
    int m_vote [2][N];
    int m_timer [2];
    bit m_res [2];
    bit m_rv [2];
    bit m_done [2];

    vote_session #(.N(5), .THRESH(3), .TIMEOUT(8), .EARLY(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vote_en(vote_en), .vote_yes(vote_yes), .busy(busy[0]), .voted(voted[0]),
        .yes_cnt(yes_cnt[0]), .no_cnt(no_cnt[0]), .result(result[0]),
        .result_valid(result_valid[0]), .done(done[0])
    );

    vote_session #(.N(5), .THRESH(3), .TIMEOUT(12), .EARLY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vote_en(vote_en), .vote_yes(vote_yes), .busy(busy[1]), .voted(voted[1]),
        .yes_cnt(yes_cnt[1]), .no_cnt(no_cnt[1]), .result(result[1]),
        .result_valid(result_valid[1]), .done(done[1])
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic int m_yes(input int k);
        int c = 0;
        for (int i = 0; i < N; i++) if (m_vote[k][i] == 1) c++;
        return c;
    endfunction

    function automatic int m_no(input int k);
        int c = 0;
        for (int i = 0; i < N; i++) if (m_vote[k][i] == 0) c++;
        return c;
    endfunction

    function automatic logic [4:0] m_mask(input int k);
        logic [4:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = (m_vote[k][i] >= 0);
        return m;
    endfunction

    task automatic m_clear(input int k);
        for (int i = 0; i < N; i++) m_vote[k][i] = -1;
        m_timer[k] = 0;
        m_res[k]   = 1'b0;
        m_rv[k]    = 1'b0;
        m_done[k]  = 1'b0;
    endtask

    // Model of one clock edge: phases 0 idle, 1 open, 2 tally, 3 hold
    task automatic m_step(input int k);
        int yc;
        int nc;
        bit closing;
        yc = m_yes(k);
        nc = m_no(k);
        m_done[k] = 1'b0;
        case (m_phase[k])
            0: if (start) begin m_clear(k); m_phase[k] = 1; end
            1: begin
                if (abort) begin
                    m_clear(k);
                    m_phase[k] = 0;
                end else begin
                    closing = (m_mask(k) == 5'b11111) || (m_timer[k] == timeout_m[k] - 1) ||
                              (early_m[k] != 0 && (yc >= TH || nc > N - TH));
                    for (int i = 0; i < N; i++)
                        if (vote_en[i] && m_vote[k][i] < 0) m_vote[k][i] = vote_yes[i] ? 1 : 0;
                    m_timer[k]++;
                    if (closing) m_phase[k] = 2;
                end
            end
            2: begin
                if (abort) begin
                    m_clear(k);
                    m_phase[k] = 0;
                end else begin
                    m_res[k]   = (yc >= TH);
                    m_rv[k]    = 1'b1;
                    m_done[k]  = 1'b1;
                    m_phase[k] = 3;
                end
            end
            default: if (start) begin m_clear(k); m_phase[k] = 1; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string label);
        string nm;
        for (int k = 0; k < 2; k++) begin
            nm = (k == 0) ? "A" : "B";
            chk($sformatf("%s %s busy", label, nm), 32'(busy[k]), 32'(m_phase[k] == 1 || m_phase[k] == 2));
            chk($sformatf("%s %s voted", label, nm), 32'(voted[k]), 32'(m_mask(k)));
            chk($sformatf("%s %s yes_cnt", label, nm), 32'(yes_cnt[k]), 32'(m_yes(k)));
            chk($sformatf("%s %s no_cnt", label, nm), 32'(no_cnt[k]), 32'(m_no(k)));
            chk($sformatf("%s %s result", label, nm), 32'(result[k]), 32'(m_res[k]));
            chk($sformatf("%s %s result_valid", label, nm), 32'(result_valid[k]), 32'(m_rv[k]));
            chk($sformatf("%s %s done", label, nm), 32'(done[k]), 32'(m_done[k]));
        end
    endtask

    // Drive one cycle of inputs at the falling edge, step the model, check after the edge
    task automatic apply_stimulus(input logic s, input logic a, input logic [4:0] en, input logic [4:0] y);
        start    = s;
        abort    = a;
        vote_en  = en;
        vote_yes = y;
        for (int k = 0; k < 2; k++) m_step(k);
        @(posedge clk);
        @(negedge clk);
        check_output("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 5'b0, 5'b0);
    endtask

    // Assert reset between edges so its asynchronous effect is observed
    task automatic do_reset();
        start    = 1'b0;
        abort    = 1'b0;
        vote_en  = '0;
        vote_yes = '0;
        rst_n    = 1'b0;
        for (int k = 0; k < 2; k++) begin m_clear(k); m_phase[k] = 0; end
        #2;
        check_output("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       rs;
        logic       ra;
        logic [4:0] ren;
        logic [4:0] ry;
        timeout_m[0] = 8;  early_m[0] = 0;
        timeout_m[1] = 12; early_m[1] = 1;
        @(negedge clk);
        do_reset();
        chk("reset A busy", 32'(busy[0]), 32'd0);
        chk("reset A done", 32'(done[0]), 32'd0);

        $display("[TB] scenario 1: separate votes Y,Y,N,Y,N");
        apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
        apply_stimulus(1'b0, 1'b0, 5'b00001, 5'b00001);
        apply_stimulus(1'b0, 1'b0, 5'b00010, 5'b00010);
        apply_stimulus(1'b0, 1'b0, 5'b00100, 5'b00000);
        apply_stimulus(1'b0, 1'b0, 5'b01000, 5'b01000);
        apply_stimulus(1'b0, 1'b0, 5'b10000, 5'b00000);
        chk("t1 A busy after last", 32'(busy[0]), 32'd1);
        idle(1);
        chk("t1 A done at k+1", 32'(done[0]), 32'd0);
        idle(1);
        chk("t1 A done at k+2", 32'(done[0]), 32'd1);
        chk("t1 A yes", 32'(yes_cnt[0]), 32'd3);
        chk("t1 A no", 32'(no_cnt[0]), 32'd2);
        chk("t1 A result", 32'(result[0]), 32'd1);
        chk("t1 B yes", 32'(yes_cnt[1]), 32'd3);
        idle(1);
        chk("t1 A done drops", 32'(done[0]), 32'd0);
        chk("t1 A valid held", 32'(result_valid[0]), 32'd1);

        $display("[TB] scenario 2: repeat strobe from one voter");
        apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
        chk("t2 valid drops", 32'(result_valid[0]), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'b00100, 5'b00100);
        apply_stimulus(1'b0, 1'b0, 5'b00100, 5'b00000);
        idle(14);
        chk("t2 A yes", 32'(yes_cnt[0]), 32'd1);
        chk("t2 A no", 32'(no_cnt[0]), 32'd0);
        chk("t2 A voted", 32'(voted[0]), 32'h04);

        $display("[TB] scenario 3: timeout with two yes votes");
        apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
        apply_stimulus(1'b0, 1'b0, 5'b00001, 5'b00001);
        apply_stimulus(1'b0, 1'b0, 5'b00010, 5'b00010);
        idle(14);
        chk("t4 A voted", 32'(voted[0]), 32'h03);
        chk("t4 A result", 32'(result[0]), 32'd0);
        chk("t4 A valid", 32'(result_valid[0]), 32'd1);

        $display("[TB] scenario 4: all voters on one cycle");
        apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
        apply_stimulus(1'b0, 1'b0, 5'b11111, 5'b10110);
        chk("t3 A yes next edge", 32'(yes_cnt[0]), 32'd3);
        chk("t3 A no next edge", 32'(no_cnt[0]), 32'd2);
        idle(2);
        chk("t3 A result", 32'(result[0]), 32'd1);
        chk("t3 A done", 32'(done[0]), 32'd1);

        $display("[TB] scenario 5: early decision");
        apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
        apply_stimulus(1'b0, 1'b0, 5'b00001, 5'b00001);
        apply_stimulus(1'b0, 1'b0, 5'b00010, 5'b00010);
        apply_stimulus(1'b0, 1'b0, 5'b00100, 5'b00100);
        idle(2);
        chk("t5 B valid", 32'(result_valid[1]), 32'd1);
        chk("t5 B result", 32'(result[1]), 32'd1);
        chk("t5 A still open", 32'(busy[0]), 32'd1);
        idle(10);

        $display("[TB] scenario 6: abort and reset mid-session");
        apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
        apply_stimulus(1'b0, 1'b0, 5'b00001, 5'b00001);
        apply_stimulus(1'b1, 1'b1, 5'b00010, 5'b00010);
        chk("t6 abort busy", 32'(busy[0]), 32'd0);
        chk("t6 abort yes", 32'(yes_cnt[0]), 32'd0);
        chk("t6 abort voted", 32'(voted[0]), 32'd0);
        idle(2);
        chk("t6 abort no done", 32'(done[0]), 32'd0);
        apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
        apply_stimulus(1'b0, 1'b0, 5'b00010, 5'b00000);
        do_reset();
        chk("t6 reset no", 32'(no_cnt[0]), 32'd0);
        idle(1);

        $display("[TB] randomized sessions");
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                rs  = ($urandom_range(0, 5) == 0);
                ra  = ($urandom_range(0, 29) == 0);
                ren = 5'($urandom) & 5'($urandom);
                ry  = 5'($urandom);
                apply_stimulus(rs, ra, ren, ry);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
